// File: rtl/y86_mem_pkg.sv
// Shared definitions for the SEQ data-memory responder: responder states,
// word geometry and byte-lane helpers used to split unaligned quadwords.
package y86_mem_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam logic [WORD_BYTES-1:0] LANE_ALL  = '1;
  localparam logic [WORD_BYTES-1:0] LANE_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_t;

  // Lanes o..7 of the first word touched by a quadword at byte offset o.
  function automatic logic [WORD_BYTES-1:0] lane_hi(input logic [2:0] off);
    return LANE_ALL << off;
  endfunction

  function automatic logic [6:0] lo_shift(input logic [2:0] off);
    return {1'b0, off, 3'b000};
  endfunction

  function automatic logic [6:0] hi_shift(input logic [2:0] off);
    return 7'd64 - lo_shift(off);
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Single-port word store with per-byte write enables and registered read data.
module dm_word_ram
  import y86_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serialises quadword loads/stores onto a word-wide
// store, splitting unaligned accesses into two beats.
module data_mem_responder
  import y86_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        readEn,
  input  logic        writeEn,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_data,
  output logic [63:0] valM,
  output logic        dm_error,
  output logic        done,
  output logic        busy
);

  localparam logic [63:0] LAST_ADDR = 64'(DEPTH * WORD_BYTES) - 64'(WORD_BYTES);

  state_t state, state_nx;

  logic                  op_wr;
  logic [AW-1:0]         widx;
  logic [2:0]            off;
  logic [63:0]           data_q;
  logic                  err_q;
  logic [63:0]           word0_q;
  logic [63:0]           val_q;
  logic                  err_hold;

  logic                  req;
  logic                  acc_err;
  logic                  ram_en;
  logic [WORD_BYTES-1:0] ram_we;
  logic [AW-1:0]         ram_addr;
  logic [63:0]           ram_wdata;
  logic [63:0]           ram_rdata;
  logic [63:0]           rd_val;

  assign req     = readEn | writeEn;
  assign acc_err = (readEn & writeEn) | (mem_addr > LAST_ADDR);

  dm_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx  = state;
    ram_en    = 1'b0;
    ram_we    = LANE_NONE;
    ram_addr  = widx;
    ram_wdata = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (req) state_nx = acc_err ? RESP : BEAT0;
      end
      BEAT0: begin
        ram_en = 1'b1;
        if (op_wr) begin
          ram_we    = lane_hi(off);
          ram_wdata = data_q << lo_shift(off);
        end
        state_nx = (off == 3'd0) ? RESP : BEAT1;
      end
      BEAT1: begin
        ram_en   = 1'b1;
        ram_addr = widx + AW'(1);
        if (op_wr) begin
          ram_we    = ~lane_hi(off);
          ram_wdata = data_q >> hi_shift(off);
        end
        state_nx = RESP;
      end
      RESP: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // In RESP the store's read register holds the last word fetched (w, or w+1
  // after a second beat) and word0_q holds word w for the unaligned case.
  always_comb begin
    rd_val = '0;
    if (!err_q && !op_wr) begin
      if (off == 3'd0) rd_val = ram_rdata;
      else             rd_val = (ram_rdata << hi_shift(off)) | (word0_q >> lo_shift(off));
    end
  end

  assign valM     = (state == RESP) ? rd_val : val_q;
  assign dm_error = (state == RESP) ? err_q  : err_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_wr    <= 1'b0;
      widx     <= '0;
      off      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      word0_q  <= '0;
      val_q    <= '0;
      err_hold <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        op_wr  <= writeEn;
        widx   <= mem_addr[AW+2:3];
        off    <= mem_addr[2:0];
        data_q <= mem_data;
        err_q  <= acc_err;
      end
      if (state == BEAT1) word0_q <= ram_rdata;
      if (state == RESP) begin
        val_q    <= rd_val;
        err_hold <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        readEn = 1'b0;
  logic        writeEn = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_data = '0;
  logic [63:0] valM;
  logic        dm_error;
  logic        done;
  logic        busy;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH (1024),
    .AW    (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .readEn   (readEn),
    .writeEn  (writeEn),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .valM     (valM),
    .dm_error (dm_error),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    logic [63:0] val;
    logic        err;
    int unsigned lat;
    int unsigned acc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [8192];
  int unsigned cycle = 0;
  int          n_pass = 0;
  int          n_checks = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  function automatic logic ref_err(input logic rd, input logic wr, input logic [63:0] a);
    return (rd && wr) || (a > 64'h1FF8);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(a[12:0]) + i];
    return v;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) ref_mem[int'(a[12:0]) + i] = d[8*i +: 8];
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, ".valM"}, valM, mon_e.val);
        check({mon_e.name, ".err"}, 64'(dm_error), 64'(mon_e.err));
        check({mon_e.name, ".lat"}, 64'(cycle - mon_e.acc + 1), 64'(mon_e.lat));
        check({mon_e.name, ".busy"}, 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, input bit perturb, input string name);
    exp_t e;
    bit   seen;
    @(negedge clk);
    readEn   = rd;
    writeEn  = wr;
    mem_addr = a;
    mem_data = d;
    e.name = name;
    e.acc  = cycle + 1;
    e.err  = ref_err(rd, wr, a);
    e.lat  = e.err ? 1 : ((a[2:0] == 3'd0) ? 2 : 3);
    e.val  = (e.err || wr) ? 64'd0 : ref_read(a);
    if (!e.err && wr) ref_write(a, d);
    sbq.push_back(e);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (perturb && busy) begin
        mem_addr = {$urandom, $urandom};
        mem_data = {$urandom, $urandom};
      end
    end
    if (!seen) begin
      check({name, ".timeout"}, 64'(done), 64'd1);
      void'(sbq.pop_back());
    end
    readEn  = 1'b0;
    writeEn = 1'b0;
  endtask

  task automatic reset_mid_write();
    logic [63:0] d;
    d = 64'hA1B2C3D4E5F60718;
    @(negedge clk);
    writeEn  = 1'b1;
    mem_addr = 64'h305;
    mem_data = d;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst.inflight_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst.valM", valM, 64'd0);
    check("rst.err", 64'(dm_error), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    writeEn = 1'b0;
    for (int i = 0; i < 3; i++) ref_mem[16'h305 + i] = d[8*i +: 8];
    @(negedge clk);
    check("rst.done_hold", 64'(done), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int unsigned k;
    repeat (3) @(negedge clk);
    check("reset.valM", valM, 64'd0);
    check("reset.err", 64'(dm_error), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) issue(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 1'b0, "fill");

    issue(1'b0, 1'b1, 64'h100, 64'h0123456789ABCDEF, 1'b0, "aligned_wr");
    issue(1'b1, 1'b0, 64'h100, 64'd0, 1'b0, "aligned_rd");
    issue(1'b0, 1'b1, 64'h200, 64'd0, 1'b0, "clr200");
    issue(1'b0, 1'b1, 64'h208, 64'd0, 1'b0, "clr208");
    issue(1'b0, 1'b1, 64'h203, 64'h1122334455667788, 1'b0, "unal_wr");
    issue(1'b1, 1'b0, 64'h200, 64'd0, 1'b0, "rd200");
    issue(1'b1, 1'b0, 64'h208, 64'd0, 1'b0, "rd208");
    issue(1'b1, 1'b0, 64'h203, 64'd0, 1'b0, "unal_rd");
    issue(1'b1, 1'b0, 64'h1FF8, 64'd0, 1'b0, "rd_last");
    issue(1'b1, 1'b0, 64'h1FF9, 64'd0, 1'b0, "rd_past");
    issue(1'b1, 1'b0, '1, 64'd0, 1'b0, "rd_ones");
    issue(1'b0, 1'b1, 64'h1FFC, 64'hDEADBEEFCAFEF00D, 1'b0, "wr_past");
    issue(1'b1, 1'b0, 64'h1FF8, 64'd0, 1'b0, "rd_last2");
    issue(1'b1, 1'b1, 64'h0, 64'h5555AAAA5555AAAA, 1'b0, "both");
    issue(1'b1, 1'b0, 64'h0, 64'd0, 1'b0, "rd0");
    issue(1'b0, 1'b1, 64'h40D, 64'h0F1E2D3C4B5A6978, 1'b1, "perturb_wr");
    issue(1'b1, 1'b0, 64'h40D, 64'd0, 1'b1, "perturb_rd");
    issue(1'b1, 1'b0, 64'h408, 64'd0, 1'b0, "perturb_rd408");

    reset_mid_write();
    issue(1'b1, 1'b0, 64'h300, 64'd0, 1'b0, "post_rst300");
    issue(1'b1, 1'b0, 64'h308, 64'd0, 1'b0, "post_rst308");

    for (int i = 0; i < 300; i++) begin
      k = $urandom % 16;
      if (k == 0)      a = {$urandom, $urandom};
      else if (k == 1) a = 64'h1FF0 + 64'($urandom % 16);
      else             a = 64'($urandom % 32'h1FF9);
      k = $urandom % 10;
      issue(k < 5, k == 0 || k >= 5, a, {$urandom, $urandom}, ($urandom % 4) == 0, "rand");
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
